// File: rtl/ddk_wb_pkg.sv
`default_nettype none
// ============================================================================
// ddk_wb_pkg : shared widths, watchdog default and FSM states for the arbiter
// Revision   : 1.0
// ============================================================================
package ddk_wb_pkg;

    localparam int DEF_AW      = 8;
    localparam int DEF_DW      = 8;
    localparam int DEF_TIMEOUT = 16;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_DONE   = 2'd2
    } wb_state_e;

    // Index width that never collapses to zero bits.
    function automatic int clog2_min1(input int value);
        return (value > 1) ? $clog2(value) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/wb_rr_pick.sv
`default_nettype none
// ============================================================================
// wb_rr_pick : combinational round-robin priority encoder
// Revision   : 1.0
// ============================================================================
module wb_rr_pick #(
    parameter int N_REQ = 2,
    parameter int IW    = 1
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IW-1:0]    last_idx,
    output logic [N_REQ-1:0] win_onehot,
    output logic [IW-1:0]    win_idx,
    output logic             win_valid
);

    int          cand;
    logic [IW-1:0] cand_idx;

    // Scan starts one past the previous winner and wraps modulo N_REQ.
    always_comb begin
        win_onehot = '0;
        win_idx    = '0;
        win_valid  = 1'b0;
        cand       = 0;
        cand_idx   = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            cand = int'(last_idx) + k;
            if (cand >= N_REQ) begin
                cand = cand - N_REQ;
            end
            cand_idx = cand[IW-1:0];
            if (!win_valid && req[cand_idx]) begin
                win_valid            = 1'b1;
                win_idx              = cand_idx;
                win_onehot[cand_idx] = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/wb_bus_arbiter.sv
`default_nettype none
// ============================================================================
// wb_bus_arbiter : round-robin share of one Wishbone-style master port
// Revision       : 1.0
// ============================================================================
module wb_bus_arbiter
    import ddk_wb_pkg::*;
#(
    parameter int N_REQ   = 2,
    parameter int AW      = DEF_AW,
    parameter int DW      = DEF_DW,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic                tb_clk,
    input  logic                tb_rst,
    input  logic [N_REQ-1:0]    req_stb,
    input  logic [N_REQ-1:0]    req_we,
    input  logic [N_REQ*AW-1:0] req_adr,
    input  logic [N_REQ*DW-1:0] req_wdat,
    output logic [N_REQ-1:0]    req_ack,
    output logic [N_REQ-1:0]    req_err,
    output logic [DW-1:0]       req_rdat,
    output logic [N_REQ-1:0]    gnt,
    output logic                m_stb_o,
    output logic                m_we_o,
    output logic [AW-1:0]       m_adr_o,
    output logic [DW-1:0]       m_dat_o,
    input  logic                m_ack_i,
    input  logic [DW-1:0]       m_dat_i,
    output logic                busy
);

    localparam int IW = clog2_min1(N_REQ);
    localparam int WW = clog2_min1(TIMEOUT + 1);

    wb_state_e         state_q,    state_d;
    logic [N_REQ-1:0]  gnt_q,      gnt_d;
    logic [IW-1:0]     gnt_idx_q,  gnt_idx_d;
    logic [IW-1:0]     last_gnt_q, last_gnt_d;
    logic              stb_q,      stb_d;
    logic              we_q,       we_d;
    logic [AW-1:0]     adr_q,      adr_d;
    logic [DW-1:0]     dat_q,      dat_d;
    logic [WW-1:0]     wd_q,       wd_d;
    logic [N_REQ-1:0]  ack_q,      ack_d;
    logic [N_REQ-1:0]  err_q,      err_d;
    logic [DW-1:0]     rdat_q,     rdat_d;

    logic [N_REQ-1:0]  pick_onehot;
    logic [IW-1:0]     pick_idx;
    logic              pick_valid;
    logic              wd_expired;
    logic [AW-1:0]     adr_arr [N_REQ];
    logic [DW-1:0]     wdat_arr[N_REQ];

    generate
        for (genvar i = 0; i < N_REQ; i++) begin : g_unpack
            assign adr_arr[i]  = req_adr[i*AW +: AW];
            assign wdat_arr[i] = req_wdat[i*DW +: DW];
        end
    endgenerate

    wb_rr_pick #(
        .N_REQ (N_REQ),
        .IW    (IW)
    ) u_pick (
        .req        (req_stb),
        .last_idx   (last_gnt_q),
        .win_onehot (pick_onehot),
        .win_idx    (pick_idx),
        .win_valid  (pick_valid)
    );

    // Expiry fires in the TIMEOUT-th ACTIVE cycle so stb stays up exactly TIMEOUT cycles.
    generate
        if (TIMEOUT > 0) begin : g_wd_on
            assign wd_expired = (wd_q == WW'(TIMEOUT - 1));
        end else begin : g_wd_off
            assign wd_expired = 1'b0;
        end
    endgenerate

    always_comb begin
        state_d    = state_q;
        gnt_d      = gnt_q;
        gnt_idx_d  = gnt_idx_q;
        last_gnt_d = last_gnt_q;
        stb_d      = stb_q;
        we_d       = we_q;
        adr_d      = adr_q;
        dat_d      = dat_q;
        wd_d       = wd_q;
        ack_d      = '0;
        err_d      = '0;
        rdat_d     = rdat_q;

        case (state_q)
            ST_IDLE: begin
                if (pick_valid) begin
                    state_d   = ST_ACTIVE;
                    gnt_d     = pick_onehot;
                    gnt_idx_d = pick_idx;
                    stb_d     = 1'b1;
                    we_d      = req_we[pick_idx];
                    adr_d     = adr_arr[pick_idx];
                    dat_d     = wdat_arr[pick_idx];
                    wd_d      = '0;
                end
            end
            ST_ACTIVE: begin
                wd_d = (wd_q == WW'(TIMEOUT)) ? wd_q : wd_q + 1'b1;
                if (m_ack_i || wd_expired) begin
                    state_d    = ST_DONE;
                    stb_d      = 1'b0;
                    gnt_d      = '0;
                    last_gnt_d = gnt_idx_q;
                    // Ack takes precedence over a coincident expiry.
                    if (m_ack_i) begin
                        ack_d  = gnt_q;
                        rdat_d = m_dat_i;
                    end else begin
                        err_d  = gnt_q;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge tb_clk or posedge tb_rst) begin
        if (tb_rst) begin
            state_q    <= ST_IDLE;
            gnt_q      <= '0;
            gnt_idx_q  <= '0;
            last_gnt_q <= IW'(N_REQ - 1);
            stb_q      <= 1'b0;
            we_q       <= 1'b0;
            adr_q      <= '0;
            dat_q      <= '0;
            wd_q       <= '0;
            ack_q      <= '0;
            err_q      <= '0;
            rdat_q     <= '0;
        end else begin
            state_q    <= state_d;
            gnt_q      <= gnt_d;
            gnt_idx_q  <= gnt_idx_d;
            last_gnt_q <= last_gnt_d;
            stb_q      <= stb_d;
            we_q       <= we_d;
            adr_q      <= adr_d;
            dat_q      <= dat_d;
            wd_q       <= wd_d;
            ack_q      <= ack_d;
            err_q      <= err_d;
            rdat_q     <= rdat_d;
        end
    end

    assign req_ack  = ack_q;
    assign req_err  = err_q;
    assign req_rdat = rdat_q;
    assign gnt      = gnt_q;
    assign m_stb_o  = stb_q;
    assign m_we_o   = we_q;
    assign m_adr_o  = adr_q;
    assign m_dat_o  = dat_q;
    assign busy     = (state_q == ST_ACTIVE) || (state_q == ST_DONE);

endmodule
`default_nettype wire

// File: tb/tb_wb_bus_arbiter.sv
`default_nettype none
// ============================================================================
// tb_wb_bus_arbiter : directed self-checking bench for wb_bus_arbiter
// Revision          : 1.0
// ============================================================================
module tb_wb_bus_arbiter;

    localparam int N_REQ = 2;
    localparam int AW    = 8;
    localparam int DW    = 8;
    localparam int TMO   = 16;

    logic                tb_clk = 1'b0;
    logic                tb_rst = 1'b1;
    logic [N_REQ-1:0]    req_stb  = '0;
    logic [N_REQ-1:0]    req_we   = '0;
    logic [N_REQ*AW-1:0] req_adr  = '0;
    logic [N_REQ*DW-1:0] req_wdat = '0;
    logic [N_REQ-1:0]    req_ack;
    logic [N_REQ-1:0]    req_err;
    logic [DW-1:0]       req_rdat;
    logic [N_REQ-1:0]    gnt;
    logic                m_stb_o;
    logic                m_we_o;
    logic [AW-1:0]       m_adr_o;
    logic [DW-1:0]       m_dat_o;
    logic                m_ack_i = 1'b0;
    logic [DW-1:0]       m_dat_i = '0;
    logic                busy;

    int total = 0;
    int bad   = 0;

    wb_bus_arbiter #(
        .N_REQ   (N_REQ),
        .AW      (AW),
        .DW      (DW),
        .TIMEOUT (TMO)
    ) dut (
        .tb_clk   (tb_clk),
        .tb_rst   (tb_rst),
        .req_stb  (req_stb),
        .req_we   (req_we),
        .req_adr  (req_adr),
        .req_wdat (req_wdat),
        .req_ack  (req_ack),
        .req_err  (req_err),
        .req_rdat (req_rdat),
        .gnt      (gnt),
        .m_stb_o  (m_stb_o),
        .m_we_o   (m_we_o),
        .m_adr_o  (m_adr_o),
        .m_dat_o  (m_dat_o),
        .m_ack_i  (m_ack_i),
        .m_dat_i  (m_dat_i),
        .busy     (busy)
    );

    always #5 tb_clk = ~tb_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        total++;
        if (obs !== exp_v) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp_v);
        end
    endtask

    // Inputs are driven and outputs sampled on the falling edge.
    task automatic tick();
        @(negedge tb_clk);
    endtask

    task automatic do_reset();
        tick();
        tb_rst  = 1'b1;
        req_stb = '0;
        m_ack_i = 1'b0;
        tick();
        tick();
        tb_rst  = 1'b0;
    endtask

    int stb_cycles;
    int err_cnt;
    int ack_cnt;
    int acks0;
    int acks1;
    logic [N_REQ-1:0] exp_g;

    initial begin
        // Reset state
        tick();
        tick();
        chk("rst_gnt",  32'(gnt),      32'h0);
        chk("rst_stb",  32'(m_stb_o),  32'h0);
        chk("rst_busy", 32'(busy),     32'h0);
        chk("rst_ack",  32'(req_ack),  32'h0);
        chk("rst_rdat", 32'(req_rdat), 32'h0);
        tb_rst = 1'b0;

        // Single read from requester 0, ack one cycle after stb
        tick();
        req_stb         = 2'b01;
        req_we          = 2'b00;
        req_adr[7:0]    = 8'h3C;
        tick();
        chk("rd_stb",  32'(m_stb_o), 32'h1);
        chk("rd_adr",  32'(m_adr_o), 32'h3C);
        chk("rd_we",   32'(m_we_o),  32'h0);
        chk("rd_gnt",  32'(gnt),     32'h1);
        chk("rd_busy", 32'(busy),    32'h1);
        m_ack_i = 1'b1;
        m_dat_i = 8'hA5;
        tick();
        chk("rd_ack",   32'(req_ack),  32'h1);
        chk("rd_rdat",  32'(req_rdat), 32'hA5);
        chk("rd_stb0",  32'(m_stb_o),  32'h0);
        chk("rd_gnt0",  32'(gnt),      32'h0);
        chk("rd_dbusy", 32'(busy),     32'h1);
        req_stb = '0;
        m_ack_i = 1'b0;
        tick();
        chk("rd_ack1",  32'(req_ack), 32'h0);
        chk("rd_ibusy", 32'(busy),    32'h0);

        // Timeout: slave never acks; rdat must keep 0xA5
        m_dat_i    = 8'hEE;
        req_stb    = 2'b01;
        stb_cycles = 0;
        err_cnt    = 0;
        ack_cnt    = 0;
        for (int i = 0; i < 24; i++) begin
            tick();
            if (m_stb_o) stb_cycles++;
            ack_cnt += int'(req_ack != '0);
            if (req_err != '0) begin
                err_cnt++;
                chk("to_err",  32'(req_err),  32'h1);
                chk("to_rdat", 32'(req_rdat), 32'hA5);
                req_stb = '0;
            end
        end
        chk("to_stb_cycles", 32'(stb_cycles), 32'd16);
        chk("to_err_cnt",    32'(err_cnt),    32'd1);
        chk("to_ack_cnt",    32'(ack_cnt),    32'd0);
        chk("to_idle",       32'(busy),       32'h0);

        // Ack on the 16th ACTIVE cycle beats expiry
        req_stb = 2'b01;
        for (int i = 1; i <= TMO; i++) begin
            tick();
            if (i == TMO) begin
                chk("co_stb16", 32'(m_stb_o), 32'h1);
                m_ack_i = 1'b1;
                m_dat_i = 8'h77;
            end
        end
        tick();
        chk("co_ack",  32'(req_ack),  32'h1);
        chk("co_err",  32'(req_err),  32'h0);
        chk("co_rdat", 32'(req_rdat), 32'h77);
        req_stb = '0;
        m_ack_i = 1'b0;
        tick();

        // Contention: both hold stb, slave acks immediately
        do_reset();
        req_stb = 2'b11;
        m_ack_i = 1'b1;
        m_dat_i = 8'h11;
        acks0   = 0;
        acks1   = 0;
        for (int t = 0; t < 4; t++) begin
            exp_g = (t % 2 == 0) ? 2'b01 : 2'b10;
            tick();
            chk($sformatf("ct_gnt%0d", t), 32'(gnt), 32'(exp_g));
            tick();
            chk($sformatf("ct_ack%0d", t), 32'(req_ack), 32'(exp_g));
            acks0 += int'(req_ack[0]);
            acks1 += int'(req_ack[1]);
            tick();
            chk($sformatf("ct_idle%0d", t), 32'({req_ack, req_err, gnt}), 32'h0);
        end
        chk("ct_acks0", 32'(acks0), 32'd2);
        chk("ct_acks1", 32'(acks1), 32'd2);

        // Write pass-through on requester 1, stable until ack
        do_reset();
        req_stb        = 2'b10;
        req_we         = 2'b10;
        req_adr[15:8]  = 8'h10;
        req_wdat[15:8] = 8'h5A;
        tick();
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("wr_hold%0d", i),
                32'({m_stb_o, m_we_o, gnt, m_adr_o, m_dat_o}), {21'h0, 1'b1, 1'b1, 2'b10, 8'h10, 8'h5A});
            req_adr[15:8]  = 8'hFF;
            req_wdat[15:8] = 8'h00;
            req_we         = 2'b00;
            tick();
        end
        m_ack_i = 1'b1;
        tick();
        chk("wr_ack", 32'(req_ack), 32'h2);
        chk("wr_err", 32'(req_err), 32'h0);
        req_stb = '0;
        m_ack_i = 1'b0;
        tick();

        // Asynchronous reset while ACTIVE on requester 1
        req_stb = 2'b10;
        tick();
        chk("ar_pre_gnt", 32'(gnt), 32'h2);
        tb_rst = 1'b1;
        #1;
        chk("ar_stb",  32'(m_stb_o), 32'h0);
        chk("ar_gnt",  32'(gnt),     32'h0);
        chk("ar_busy", 32'(busy),    32'h0);
        tick();
        req_stb = 2'b11;
        tb_rst  = 1'b0;
        tick();
        chk("ar_first", 32'(gnt), 32'h1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
